// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM state encoding,
// the default drain bound and the mstatus bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    REDIRECT,
    RET
  } state_e;

  localparam int DRAIN_MAX_DEFAULT = 15;
  localparam int MSTATUS_MIE_BIT   = 3;
  localparam int MSTATUS_MPIE_BIT  = 7;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline <-> trap controller signal bundle. The pipeline side is the master
// (drives requests and CSR state); the trap controller is the slave.
interface trap_ctrl_if;

  logic        interrupt;
  logic        exception;
  logic [4:0]  int_code;
  logic [31:0] trap_pc;
  logic [31:0] pc_addr;
  logic        mret;
  logic [31:0] mepc;
  logic        pipe_idle;
  logic        csr_mstatus_we;
  logic [31:0] csr_mstatus_wdata;

  logic        stall;
  logic        flush;
  logic        pc_sel;
  logic [31:0] pc_next;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        mcause_we;
  logic [31:0] mcause_wdata;
  logic        MIE;
  logic        MPIE;
  logic        busy;

  modport master (
    output interrupt, exception, int_code, trap_pc, pc_addr, mret, mepc,
           pipe_idle, csr_mstatus_we, csr_mstatus_wdata,
    input  stall, flush, pc_sel, pc_next, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, MIE, MPIE, busy
  );

  modport slave (
    input  interrupt, exception, int_code, trap_pc, pc_addr, mret, mepc,
           pipe_idle, csr_mstatus_we, csr_mstatus_wdata,
    output stall, flush, pc_sel, pc_next, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, MIE, MPIE, busy
  );

endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains the pipe, writes mepc/mcause, redirects
// to the handler, and services MRET. All outputs are registered.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  trap_ctrl_if.slave bus
);

  localparam logic [3:0] DRAIN_LIMIT = 4'(DRAIN_MAX);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [29:0] r_trap_pc;
  logic [4:0]  r_code;
  logic [31:0] r_pc_addr;
  logic        r_is_irq;
  logic        r_stall;
  logic        r_flush;
  logic        r_pc_sel;
  logic [31:0] r_pc_next;
  logic        r_mepc_we;
  logic [31:0] r_mepc_wdata;
  logic        r_mcause_we;
  logic [31:0] r_mcause_wdata;
  logic        r_mie;
  logic        r_mpie;

  logic        w_trap_req;
  logic [3:0]  w_cnt_inc;
  logic        w_drain_done;
  logic        w_unused;

  assign w_trap_req = bus.exception | bus.interrupt;
  assign w_cnt_inc  = r_cnt + 4'd1;
  // The counter reaches DRAIN_LIMIT on the same edge that leaves DRAIN, which
  // bounds the drain at DRAIN_MAX cycles.
  assign w_drain_done = bus.pipe_idle | (w_cnt_inc == DRAIN_LIMIT);

  assign w_unused = ^{bus.trap_pc[1:0], bus.csr_mstatus_wdata[31:8],
                      bus.csr_mstatus_wdata[6:4], bus.csr_mstatus_wdata[2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_trap_pc      <= '0;
      r_code         <= '0;
      r_pc_addr      <= '0;
      r_is_irq       <= 1'b0;
      r_stall        <= 1'b0;
      r_flush        <= 1'b0;
      r_pc_sel       <= 1'b0;
      r_pc_next      <= '0;
      r_mepc_we      <= 1'b0;
      r_mepc_wdata   <= '0;
      r_mcause_we    <= 1'b0;
      r_mcause_wdata <= '0;
      r_mie          <= 1'b0;
      r_mpie         <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and only the transition into a
      // state raises them; later assignments in the same block win.
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_sel    <= 1'b0;
      r_mepc_we   <= 1'b0;
      r_mcause_we <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.csr_mstatus_we) begin
            r_mie  <= bus.csr_mstatus_wdata[MSTATUS_MIE_BIT];
            r_mpie <= bus.csr_mstatus_wdata[MSTATUS_MPIE_BIT];
          end
          if (w_trap_req) begin
            r_trap_pc <= bus.trap_pc[31:2];
            r_code    <= bus.int_code;
            r_pc_addr <= bus.pc_addr;
            r_is_irq  <= ~bus.exception;
            r_cnt     <= '0;
            r_stall   <= 1'b1;
            r_state   <= DRAIN;
          end else if (bus.mret) begin
            r_flush   <= 1'b1;
            r_pc_sel  <= 1'b1;
            r_pc_next <= bus.mepc;
            r_mie     <= r_mpie;
            r_mpie    <= 1'b1;
            r_state   <= RET;
          end
        end

        DRAIN: begin
          r_stall <= 1'b1;
          r_cnt   <= w_cnt_inc;
          if (w_drain_done) begin
            r_mepc_we      <= 1'b1;
            r_mcause_we    <= 1'b1;
            r_mepc_wdata   <= {r_trap_pc, 2'b00};
            r_mcause_wdata <= {r_is_irq, 26'b0, r_code};
            r_state        <= SAVE;
          end
        end

        SAVE: begin
          r_mpie    <= r_mie;
          r_mie     <= 1'b0;
          r_flush   <= 1'b1;
          r_pc_sel  <= 1'b1;
          r_pc_next <= r_pc_addr;
          r_state   <= REDIRECT;
        end

        REDIRECT: r_state <= IDLE;
        RET:      r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall        = r_stall;
  assign bus.flush        = r_flush;
  assign bus.pc_sel       = r_pc_sel;
  assign bus.pc_next      = r_pc_next;
  assign bus.mepc_we      = r_mepc_we;
  assign bus.mepc_wdata   = r_mepc_wdata;
  assign bus.mcause_we    = r_mcause_we;
  assign bus.mcause_wdata = r_mcause_wdata;
  assign bus.MIE          = r_mie;
  assign bus.MPIE         = r_mpie;
  assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: expected trap results are queued when a
// request is driven and compared when the SAVE/REDIRECT cycles appear.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic reset;

  trap_ctrl_if ifc ();

  trap_ctrl #(.DRAIN_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] target;
    logic        mie;
    logic        mpie;
    int          save_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic m_mie = 1'b0;
  logic m_mpie = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.interrupt = 1'b0;
    ifc.exception = 1'b0;
    ifc.int_code = '0;
    ifc.trap_pc = '0;
    ifc.pc_addr = '0;
    ifc.mret = 1'b0;
    ifc.mepc = '0;
    ifc.pipe_idle = 1'b0;
    ifc.csr_mstatus_we = 1'b0;
    ifc.csr_mstatus_wdata = '0;
  endtask

  task automatic release_req();
    ifc.exception = 1'b0;
    ifc.interrupt = 1'b0;
    ifc.mret = 1'b0;
  endtask

  // Drives a trap request for the coming edge and queues what it must produce.
  task automatic push_trap(input logic exc, input logic irq, input logic [4:0] code,
                           input logic [31:0] tpc, input logic [31:0] addr,
                           input logic idle, input int save_cyc);
    exp_t e;
    e.mepc     = {tpc[31:2], 2'b00};
    e.mcause   = {~exc, 26'b0, code};
    e.target   = addr;
    e.mie      = 1'b0;
    e.mpie     = m_mie;
    e.save_cyc = save_cyc;
    sb_q.push_back(e);
    m_mpie = m_mie;
    m_mie  = 1'b0;
    ifc.exception = exc;
    ifc.interrupt = irq;
    ifc.int_code  = code;
    ifc.trap_pc   = tpc;
    ifc.pc_addr   = addr;
    ifc.pipe_idle = idle;
  endtask

  task automatic csr_write(input logic [31:0] data);
    ifc.csr_mstatus_we = 1'b1;
    ifc.csr_mstatus_wdata = data;
    tick();
    ifc.csr_mstatus_we = 1'b0;
    m_mie  = data[3];
    m_mpie = data[7];
    n_vec++;
    if (ifc.MIE !== m_mie || ifc.MPIE !== m_mpie) begin
      n_err++;
      $display("FAIL csr_write MIE/MPIE: got %b/%b expected %b/%b", ifc.MIE, ifc.MPIE, m_mie, m_mpie);
    end
  endtask

  // Waits (bounded) for SAVE, pops the scoreboard and checks SAVE, REDIRECT, IDLE.
  task automatic observe_trap(input string name, input int cyc0);
    exp_t e;
    int   cyc = cyc0;
    int   stall_cycles = 0;
    bit   seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) release_req();
      if (ifc.mepc_we === 1'b1) seen = 1'b1;
      else if (ifc.stall === 1'b1) stall_cycles++;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: no mepc_we within %0d cycles", name, cyc);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    n_vec++;
    if (cyc !== e.save_cyc) begin
      n_err++; $display("FAIL %s save_cycle: got %0d expected %0d", name, cyc, e.save_cyc);
    end
    n_vec++;
    if (stall_cycles !== e.save_cyc - 1 - cyc0) begin
      n_err++; $display("FAIL %s drain_stall_cycles: got %0d expected %0d", name, stall_cycles, e.save_cyc - 1 - cyc0);
    end
    n_vec++;
    if (ifc.mepc_wdata !== e.mepc || ifc.mcause_we !== 1'b1 || ifc.stall !== 1'b1) begin
      n_err++; $display("FAIL %s save mepc_wdata/mcause_we/stall: got %h/%b/%b expected %h/1/1", name, ifc.mepc_wdata, ifc.mcause_we, ifc.stall, e.mepc);
    end
    n_vec++;
    if (ifc.mcause_wdata !== e.mcause) begin
      n_err++; $display("FAIL %s mcause_wdata: got %h expected %h", name, ifc.mcause_wdata, e.mcause);
    end
    tick();
    n_vec++;
    if (ifc.flush !== 1'b1 || ifc.pc_sel !== 1'b1 || ifc.pc_next !== e.target ||
        ifc.mepc_we !== 1'b0 || ifc.stall !== 1'b0) begin
      n_err++; $display("FAIL %s redirect flush/pc_sel/pc_next/mepc_we/stall: got %b/%b/%h/%b/%b expected 1/1/%h/0/0", name, ifc.flush, ifc.pc_sel, ifc.pc_next, ifc.mepc_we, ifc.stall, e.target);
    end
    n_vec++;
    if (ifc.MIE !== e.mie || ifc.MPIE !== e.mpie) begin
      n_err++; $display("FAIL %s MIE/MPIE after save: got %b/%b expected %b/%b", name, ifc.MIE, ifc.MPIE, e.mie, e.mpie);
    end
    tick();
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.flush !== 1'b0 || ifc.pc_sel !== 1'b0) begin
      n_err++; $display("FAIL %s back_to_idle busy/flush/pc_sel: got %b/%b/%b expected 0/0/0", name, ifc.busy, ifc.flush, ifc.pc_sel);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #12;
    n_vec++;
    if ({ifc.stall, ifc.flush, ifc.pc_sel, ifc.mepc_we, ifc.mcause_we, ifc.MIE, ifc.MPIE, ifc.busy} !== 8'b0 ||
        ifc.pc_next !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: got strobes %b pc_next %h expected 0", {ifc.stall, ifc.flush, ifc.pc_sel, ifc.mepc_we, ifc.mcause_we, ifc.MIE, ifc.MPIE, ifc.busy}, ifc.pc_next);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.stall !== 1'b0) begin
      n_err++; $display("FAIL reset_idle busy/stall: got %b/%b expected 0/0", ifc.busy, ifc.stall);
    end
    m_mie = 1'b0;
    m_mpie = 1'b0;
  endtask

  task automatic test_exception();
    csr_write(32'h0000_0008);
    push_trap(1'b1, 1'b0, 5'd2, 32'h104, 32'h80, 1'b1, 2);
    observe_trap("exception", 0);
  endtask

  task automatic test_priority();
    push_trap(1'b1, 1'b1, 5'd4, 32'h2003, 32'h300, 1'b1, 2);
    observe_trap("exc_over_irq", 0);
    push_trap(1'b1, 1'b0, 5'd1, 32'h40, 32'h500, 1'b1, 2);
    ifc.mret = 1'b1;
    ifc.mepc = 32'hDEAD_0000;
    observe_trap("trap_over_mret", 0);
  endtask

  task automatic test_drain_timeout();
    push_trap(1'b0, 1'b1, 5'd7, 32'h1000, 32'h84, 1'b0, 16);
    observe_trap("drain_timeout", 0);
  endtask

  task automatic test_mret();
    csr_write(32'h0000_0080);
    ifc.mret = 1'b1;
    ifc.mepc = 32'h200;
    tick();
    ifc.mret = 1'b0;
    m_mie = m_mpie;
    m_mpie = 1'b1;
    n_vec++;
    if (ifc.flush !== 1'b1 || ifc.pc_sel !== 1'b1 || ifc.pc_next !== 32'h200 || ifc.busy !== 1'b1 || ifc.stall !== 1'b0) begin
      n_err++; $display("FAIL mret flush/pc_sel/pc_next/busy/stall: got %b/%b/%h/%b/%b expected 1/1/00000200/1/0", ifc.flush, ifc.pc_sel, ifc.pc_next, ifc.busy, ifc.stall);
    end
    n_vec++;
    if (ifc.MIE !== m_mie || ifc.MPIE !== m_mpie) begin
      n_err++; $display("FAIL mret MIE/MPIE: got %b/%b expected %b/%b", ifc.MIE, ifc.MPIE, m_mie, m_mpie);
    end
    tick();
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.flush !== 1'b0) begin
      n_err++; $display("FAIL mret_done busy/flush: got %b/%b expected 0/0", ifc.busy, ifc.flush);
    end
  endtask

  task automatic test_back_to_back();
    push_trap(1'b1, 1'b0, 5'd11, 32'h600, 32'h700, 1'b0, 3);
    tick();
    release_req();
    ifc.mret = 1'b1;
    ifc.interrupt = 1'b1;
    ifc.mepc = 32'h9999_0000;
    tick();
    release_req();
    ifc.pipe_idle = 1'b1;
    observe_trap("ignore_while_busy", 2);
    push_trap(1'b0, 1'b1, 5'd3, 32'h800, 32'h900, 1'b1, 2);
    observe_trap("back_to_back", 0);
  endtask

  task automatic test_reset_in_save();
    bit stray = 1'b0;
    ifc.exception = 1'b1;
    ifc.int_code = 5'd5;
    ifc.trap_pc = 32'hA00;
    ifc.pc_addr = 32'hB00;
    ifc.pipe_idle = 1'b1;
    tick();
    release_req();
    tick();
    n_vec++;
    if (ifc.mepc_we !== 1'b1) begin
      n_err++; $display("FAIL reset_in_save reached_save: got mepc_we %b expected 1", ifc.mepc_we);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({ifc.stall, ifc.mepc_we, ifc.mcause_we, ifc.flush, ifc.busy, ifc.MIE, ifc.MPIE} !== 7'b0 || ifc.pc_next !== 32'h0) begin
      n_err++; $display("FAIL reset_in_save async_clear: got %b pc_next %h expected 0", {ifc.stall, ifc.mepc_we, ifc.mcause_we, ifc.flush, ifc.busy, ifc.MIE, ifc.MPIE}, ifc.pc_next);
    end
    @(negedge clk);
    reset = 1'b0;
    m_mie = 1'b0;
    m_mpie = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc.mepc_we !== 1'b0 || ifc.mcause_we !== 1'b0 || ifc.busy !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_err++; $display("FAIL reset_in_save after_release: got stray write/busy expected none");
    end
  endtask

  task automatic test_csr_gating();
    push_trap(1'b0, 1'b1, 5'd9, 32'hC00, 32'hD00, 1'b0, 3);
    tick();
    release_req();
    ifc.csr_mstatus_we = 1'b1;
    ifc.csr_mstatus_wdata = 32'h0000_0088;
    tick();
    ifc.csr_mstatus_we = 1'b0;
    n_vec++;
    if (ifc.MIE !== 1'b0 || ifc.MPIE !== 1'b0) begin
      n_err++; $display("FAIL csr_gated_in_drain MIE/MPIE: got %b/%b expected 0/0", ifc.MIE, ifc.MPIE);
    end
    ifc.pipe_idle = 1'b1;
    observe_trap("csr_gating", 2);
    csr_write(32'h0000_0008);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exception();
    test_priority();
    test_drain_timeout();
    test_mret();
    test_back_to_back();
    test_reset_in_save();
    test_csr_gating();
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_empty: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_MAX, default 15, meaning the maximum number of DRAIN cycles before forced progress.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port interrupt  in  1  enabled pending interrupt, qualified upstream.
REQ-005 SHALL have port exception  in  1  synchronous exception at the MEM stage.
REQ-006 SHALL have port int_code  in  5  cause code for the current trap.
REQ-007 SHALL have port trap_pc  in  32  PC of the faulting or interrupted instruction.
REQ-008 SHALL have port pc_addr  in  32  handler target (direct or vectored).
REQ-009 SHALL have port mret  in  1  MRET retiring at MEM.
REQ-010 SHALL have port mepc  in  32  current mepc CSR value.
REQ-011 SHALL have port pipe_idle  in  1  no outstanding memory transaction or stall.
REQ-012 SHALL have port csr_mstatus_we  in  1  software write of mstatus.
REQ-013 SHALL have port csr_mstatus_wdata  in  32  mstatus write data (bit3 MIE, bit7 MPIE).
REQ-014 SHALL have port stall  out  1  hold the front end.
REQ-015 SHALL have port flush  out  1  kill IF..MEM.
REQ-016 SHALL have port pc_sel  out  1  select pc_next at the PC register.
REQ-017 SHALL have port pc_next  out  32  redirect target.
REQ-018 SHALL have port mepc_we  out  1  mepc write strobe.
REQ-019 SHALL have port mepc_wdata  out  32  mepc write data.
REQ-020 SHALL have port mcause_we  out  1  mcause write strobe.
REQ-021 SHALL have port mcause_wdata  out  32  mcause write data.
REQ-022 SHALL have port MIE  out  1  mstatus.MIE.
REQ-023 SHALL have port MPIE  out  1  mstatus.MPIE.
REQ-024 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-025 SHALL implement FSM states IDLE, DRAIN, SAVE, REDIRECT, RET.
REQ-026 In IDLE, when exception or interrupt is high, SHALL latch trap_pc, int_code, pc_addr and is_irq=~exception, then go to DRAIN; exception SHALL win over interrupt.
REQ-027 In IDLE, when mret is high and no trap is requested, SHALL go to RET; a trap SHALL win over mret.
REQ-028 DRAIN SHALL assert stall and increment a 4-bit counter, cleared on DRAIN entry.
REQ-029 DRAIN SHALL go to SAVE on pipe_idle=1 or on the cycle the counter equals DRAIN_MAX, whichever comes first.
REQ-030 SAVE SHALL last 1 cycle with stall=1, mepc_we=1, mcause_we=1, mepc_wdata={latched trap_pc[31:2],2'b00} and mcause_wdata={is_irq,26'b0,latched code}.
REQ-031 On SAVE exit, SHALL set MPIE<=MIE and MIE<=0.
REQ-032 REDIRECT SHALL last 1 cycle with flush=1, pc_sel=1, pc_next=latched pc_addr, then return to IDLE.
REQ-033 RET SHALL last 1 cycle with flush=1, pc_sel=1, pc_next=mepc, MIE<=MPIE, MPIE<=1, then return to IDLE.
REQ-034 Trap-to-redirect latency SHALL be 1 (DRAIN minimum) + 1 + 1 = 3 cycles when pipe_idle is already high.
REQ-035 interrupt, exception and mret SHALL be ignored outside IDLE; no request queueing.
REQ-036 csr_mstatus_we SHALL update MIE/MPIE only in IDLE; FSM updates SHALL take precedence in SAVE and RET.
REQ-037 stall, flush, pc_sel, mepc_we and mcause_we SHALL be 0 in IDLE.
REQ-038 busy SHALL equal (state != IDLE).

Reset
REQ-039 reset SHALL force, asynchronously: state=IDLE, counter=0, MIE=0, MPIE=0, all latches=0, all strobes=0, pc_next=0.
REQ-040 Reset asserted mid-sequence SHALL abandon the sequence with no CSR write after deassertion.

Structure
REQ-041 Package trap_pkg SHALL hold the state enum, DRAIN_MAX default and MSTATUS_MIE_BIT=3 / MSTATUS_MPIE_BIT=7 constants.
REQ-042 The block SHALL be a single module with no sub-module; the drain counter SHALL be inline.

Verification
REQ-043 Test: MIE=1, exception=1, int_code=2, trap_pc=0x104, pc_addr=0x80, pipe_idle=1 -> mepc_wdata=0x104, mcause_wdata=0x2, pc_next=0x80 at cycle 3, MIE=0, MPIE=1.
REQ-044 Test: exception and interrupt asserted in the same cycle with int_code=4 -> mcause_wdata=0x4 (bit31=0).
REQ-045 Test: interrupt, int_code=7, pipe_idle held 0 -> stall for 15 DRAIN cycles, then SAVE with mcause_wdata=0x80000007.
REQ-046 Test: mret with mepc=0x200, MPIE=1 -> next cycle flush=1, pc_next=0x200, MIE=1, MPIE=1, busy falls after 1 cycle.
REQ-047 Test: reset pulsed in SAVE -> outputs 0 immediately, no mepc_we after release, state=IDLE.
REQ-048 Test: csr_mstatus_we with MIE bit set during DRAIN -> ignored; the same write in IDLE sets MIE=1 the next cycle.
